// File: rtl/bit_serial_adder_pkg.sv
// Shared constants and types for the bit-serial adder.
package bit_serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/bit_1_full_adder.sv
// One-bit full adder: s_i = a ^ b ^ cin, c_i = carry out.
module bit_1_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i_1,
  output logic s_i,
  output logic c_i
);

  // Pure gate-level sum and majority carry
  always_comb begin
    s_i = a_i ^ b_i ^ c_i_1;
    c_i = (a_i & b_i) | (a_i & c_i_1) | (b_i & c_i_1);
  end

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial unsigned adder: LSB-first, one bit per clock through a single full adder.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fa_s, fa_c;
  logic             last_bit;

  bit_1_full_adder u_fa (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .c_i_1 (carry_q),
    .s_i   (fa_s),
    .c_i   (fa_c)
  );

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  // State register; reset wins over every transition
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  // Datapath next-state: load on accepted start, shift one bit per RUN cycle
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (state_q == StIdle && start) begin
      a_d     = a_in;
      b_d     = b_in;
      carry_d = 1'b0;
      cnt_d   = '0;
    end else if (state_q == StRun) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      // Sum bit enters at the MSB so the LSB-first result ends up aligned
      psum_d  = WIDTH'({fa_s, psum_q} >> 1);
      carry_d = fa_c;
      cnt_d   = cnt_q + CntW'(1);
      if (last_bit) begin
        sum_d  = psum_d;
        cout_d = fa_c;
      end
    end
  end

  // Datapath registers; reset also clears the visible result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder (WIDTH=8).
module tb_bit_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         c_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W:0] exp_q[$];
  int         t_q[$];
  logic [W:0] hold_exp = '0;
  int         busy_run = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: pop expectation on done, check result, latency and busy length
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (busy === 1'b1) begin
        busy_run++;
        check_eq("hold_during_run", {23'd0, c_out, sum}, {23'd0, hold_exp});
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_done", 32'(done), 32'd0);
        end else begin
          hold_exp = exp_q.pop_front();
          check_eq("result", {23'd0, c_out, sum}, {23'd0, hold_exp});
          check_eq("latency", 32'(cyc - t_q.pop_front()), W);
          check_eq("busy_len", 32'(busy_run), W);
          check_eq("busy_in_done", 32'(busy), 32'd0);
        end
        busy_run = 0;
      end
    end
  end

  // Wait until all expectations are retired, then land in IDLE
  task automatic wait_idle();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("done_timeout", 32'(exp_q.size()), 32'd0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      t_q.delete();
    end
    @(negedge clk);
  endtask

  // One-cycle start pulse; called at a negedge with the DUT in IDLE
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    exp_q.push_back({1'b0, a} + {1'b0, b});
    t_q.push_back(cyc);
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    wait_idle();
  endtask

  initial begin
    int t0;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_cout", 32'(c_out), 32'd0);
    // start must not beat reset
    start = 1'b1;
    a_in  = 8'd9;
    b_in  = 8'd9;
    @(negedge clk);
    check_eq("rst_prio_busy", 32'(busy), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    do_op(8'd3, 8'd5);
    do_op(8'd255, 8'd1);
    do_op(8'd255, 8'd255);
    do_op(8'd170, 8'd85);
    do_op(8'd0, 8'd0);
    do_op(8'd128, 8'd128);

    // start held for 12 edges; operands change during RUN
    start = 1'b1;
    a_in  = 8'd10;
    b_in  = 8'd20;
    @(negedge clk);
    t0 = cyc;
    exp_q.push_back(9'd30);
    t_q.push_back(cyc);
    for (int i = 1; i <= 11; i++) begin
      if (i == 2) begin
        a_in = 8'd1;
        b_in = 8'd1;
      end
      @(negedge clk);
      if (cyc == t0 + W + 2) begin
        exp_q.push_back(9'd2);
        t_q.push_back(cyc);
      end
    end
    start = 1'b0;
    wait_idle();

    // Abort mid-RUN with reset at RUN cycle 4
    start = 1'b1;
    a_in  = 8'd200;
    b_in  = 8'd100;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    t_q.delete();
    @(negedge clk);
    rst      = 1'b0;
    hold_exp = '0;
    busy_run = 0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_sum", 32'(sum), 32'd0);
    check_eq("abort_cout", 32'(c_out), 32'd0);
    for (int i = 0; i < 12; i++) @(negedge clk);
    do_op(8'd200, 8'd100);

    // Corners plus random operand pairs against the reference sum
    for (int i = 0; i < 16; i++) do_op(8'(i * 17), 8'(255 - i * 17));
    for (int i = 0; i < 1200; i++) do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to add a_in and b_in; sampled only in IDLE.
REQ-005 SHALL have port a_in  input  WIDTH  operand A, unsigned, captured on the accepted start edge.
REQ-006 SHALL have port b_in  input  WIDTH  operand B, unsigned, captured on the accepted start edge.
REQ-007 SHALL have port busy  output  1  high while the serial addition is in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse when sum and c_out become valid.
REQ-009 SHALL have port sum  output  WIDTH  registered result (a_in + b_in) mod 2^WIDTH.
REQ-010 SHALL have port c_out  output  1  registered carry out of the MSB.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE: start=1 at an edge SHALL load the A and B shift registers, clear the carry flop, clear the bit counter, and move to RUN; start=0 SHALL keep the FSM in IDLE.
REQ-013 RUN: each edge SHALL add a_reg[0], b_reg[0] and the carry flop in one full adder, shift A and B right by one bit, shift the sum bit into the MSB of the partial-sum register, store the carry-out in the carry flop, and increment the counter.
REQ-014 RUN SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1 the FSM SHALL move to DONE and copy the partial sum and final carry into sum and c_out.
REQ-015 DONE SHALL last exactly one cycle with done=1, then move to IDLE unconditionally.
REQ-016 Latency: for start accepted at edge T, done SHALL be high during the cycle after edge T+WIDTH, and sum/c_out SHALL be valid from that cycle onward.
REQ-017 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; both SHALL be registered-state decodes with no combinational path from start.
REQ-018 sum and c_out SHALL hold their value until the next DONE and SHALL NOT toggle during RUN.
REQ-019 start asserted in RUN or DONE SHALL be ignored, with no queuing; a new start is accepted on the first IDLE cycle.
REQ-020 a_in and b_in changes after the accepted start edge SHALL NOT affect the result.
REQ-021 Overflow SHALL wrap modulo 2^WIDTH, with the lost bit reported on c_out.
REQ-022 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, c_out=0, and clear the shift registers, carry flop and counter.
REQ-024 rst SHALL take priority over start and all FSM transitions.
REQ-025 rst asserted mid-RUN SHALL abort the operation: no done pulse, and sum/c_out cleared to 0.

Structure
REQ-026 The FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH SHALL be constants in the shared package bit_serial_adder_pkg.
REQ-027 The per-bit addition SHALL instantiate the existing bit_1_full_adder as the single sub-module (ports a_i, b_i, c_i_1, s_i, c_i); no other arithmetic operators on the data path.
REQ-028 The implementation SHALL be fully synchronous, with no latches and no gated clocks.

Verification
REQ-029 With WIDTH=8, start with a_in=3, b_in=5 -> busy high for 8 cycles, then done for 1 cycle with sum=8, c_out=0.
REQ-030 a_in=255, b_in=1 -> sum=0, c_out=1; a_in=255, b_in=255 -> sum=254, c_out=1; a_in=170, b_in=85 -> sum=255, c_out=0.
REQ-031 start held high for 12 cycles with a_in=10, b_in=20, and operands changed to 1 and 1 during RUN -> exactly one done with sum=30; a second operation starts the cycle after DONE and yields sum=2 on its own done.
REQ-032 rst pulsed at RUN cycle 4 of 200+100 -> no done, and sum=0, c_out=0, busy=0 on the next cycle; a following start with 200+100 -> sum=44, c_out=1.
REQ-033 Sweep all 65536 operand pairs against a reference model -> {c_out,sum}==a_in+b_in for every pair, with done exactly 8 cycles after each accepted start edge.
